ann_load_sequencer: RTL and testbench

- Input-stream demultiplexer for the fast-ANN user project.
- Takes the 11-bit word stream arriving on the chip IO input FIFO and writes each word to the correct memory:
  - KD-tree internal-node memory
  - leaf-patch memory
  - query-patch memory
- Placement: between the in-FIFO dequeue side and the three SRAM write ports.
- Signals completion to the search FSM and exposes progress status for the debug/Wishbone path.

---
 rtl/ann_pkg.sv | 28 ++
 rtl/ann_wrap_counter.sv | 28 ++
 rtl/ann_load_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ann_load_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared sizes, section lengths and load state encoding for the ANN load path
package ann_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int LEAF_SIZE  = 8;
  localparam int PATCH_SIZE = 5;
  localparam int NUM_LEAVES = 64;
  localparam int NUM_QUERYS = 494;

  // Words per section of the input stream
  localparam int NODE_WORDS  = 2 * (NUM_LEAVES - 1);
  localparam int LEAF_WORDS  = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
  localparam int QUERY_WORDS = NUM_QUERYS * PATCH_SIZE;

  // Last value of each counter level, per section
  localparam int NODE_IDX_LAST  = NODE_WORDS / 2 - 1;
  localparam int LEAF_IDX_LAST  = NUM_LEAVES - 1;
  localparam int QUERY_IDX_LAST = QUERY_WORDS / PATCH_SIZE - 1;
  localparam int PATCH_LAST     = LEAF_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NODES   = 2'd1,
    LEAVES  = 2'd2,
    QUERIES = 2'd3
  } load_state_t;

endpackage

// File: rtl/ann_wrap_counter.sv
// rtl/ann_wrap_counter.sv - modulo counter with runtime terminal value, clear and wrap output
module ann_wrap_counter #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  // Wrap is only meaningful on an enabled step so it can drive the next level's enable
  assign o_wrap  = i_en && (r_count == i_max);
  assign o_count = r_count;

  // Clear dominates; on wrap the count returns to zero for the next group
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ann_load_sequencer.sv
// rtl/ann_load_sequencer.sv - input-stream demux to node/leaf/query memories; LOAD_PERF_CNT_EN adds cycle counters
module ann_load_sequencer
  import ann_pkg::*;
(
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  load_kdtree,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  node_we,
  output logic [5:0]            node_addr,
  output logic                  node_sel,
  output logic                  leaf_we,
  output logic [5:0]            leaf_addr,
  output logic [2:0]            leaf_patch,
  output logic [2:0]            leaf_word,
  output logic                  query_we,
  output logic [8:0]            query_addr,
  output logic [2:0]            query_word,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  load_done,
  output logic [1:0]            state,
  output logic [31:0]           kdtree_cycles,
  output logic [31:0]           query_cycles
);

  load_state_t           r_state;
  logic                  r_node_we, r_node_sel, r_leaf_we, r_query_we, r_load_done;
  logic [5:0]            r_node_addr, r_leaf_addr;
  logic [2:0]            r_leaf_patch, r_leaf_word, r_query_word;
  logic [8:0]            r_query_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic       w_accept, w_clr;
  logic [2:0] w_word, w_word_max, w_patch;
  logic [8:0] w_idx, w_idx_max;
  logic       w_word_wrap, w_patch_wrap, w_idx_wrap;
  logic       w_patch_en, w_idx_en;

  // A beat arriving together with a restart pulse is discarded
  assign w_accept = in_valid && in_ready && !load_kdtree;
  assign w_clr    = io_rst || load_kdtree;

  // Per-section terminal values for the word and index levels
  always_comb begin
    w_word_max = 3'(PATCH_SIZE - 1);
    w_idx_max  = 9'(QUERY_IDX_LAST);
    case (r_state)
      NODES: begin
        w_word_max = 3'd1;
        w_idx_max  = 9'(NODE_IDX_LAST);
      end
      LEAVES: begin
        w_word_max = 3'(PATCH_SIZE);
        w_idx_max  = 9'(LEAF_IDX_LAST);
      end
      default: ;
    endcase
  end

  // Only leaves have a patch level; elsewhere the index advances straight off the word level
  assign w_patch_en = w_word_wrap && (r_state == LEAVES);
  assign w_idx_en   = (r_state == LEAVES) ? w_patch_wrap : w_word_wrap;

  ann_wrap_counter #(.WIDTH(3)) u_word_cnt (
    .i_clk(io_clk), .i_clr(w_clr), .i_en(w_accept), .i_max(w_word_max),
    .o_count(w_word), .o_wrap(w_word_wrap)
  );

  ann_wrap_counter #(.WIDTH(3)) u_patch_cnt (
    .i_clk(io_clk), .i_clr(w_clr), .i_en(w_patch_en), .i_max(3'(PATCH_LAST)),
    .o_count(w_patch), .o_wrap(w_patch_wrap)
  );

  ann_wrap_counter #(.WIDTH(9)) u_idx_cnt (
    .i_clk(io_clk), .i_clr(w_clr), .i_en(w_idx_en), .i_max(w_idx_max),
    .o_count(w_idx), .o_wrap(w_idx_wrap)
  );

  // Section FSM with registered write strobes; the index wrap marks the last word of a section
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_state      <= IDLE;
      r_node_we    <= 1'b0;
      r_node_addr  <= '0;
      r_node_sel   <= 1'b0;
      r_leaf_we    <= 1'b0;
      r_leaf_addr  <= '0;
      r_leaf_patch <= '0;
      r_leaf_word  <= '0;
      r_query_we   <= 1'b0;
      r_query_addr <= '0;
      r_query_word <= '0;
      r_wdata      <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_node_we   <= 1'b0;
      r_leaf_we   <= 1'b0;
      r_query_we  <= 1'b0;
      r_load_done <= 1'b0;
      if (load_kdtree) begin
        r_state <= NODES;
      end else if (w_accept) begin
        r_wdata <= in_data;
        case (r_state)
          NODES: begin
            r_node_we   <= 1'b1;
            r_node_addr <= w_idx[5:0];
            r_node_sel  <= w_word[0];
            if (w_idx_wrap) r_state <= LEAVES;
          end
          LEAVES: begin
            r_leaf_we    <= 1'b1;
            r_leaf_addr  <= w_idx[5:0];
            r_leaf_patch <= w_patch;
            r_leaf_word  <= w_word;
            if (w_idx_wrap) r_state <= QUERIES;
          end
          QUERIES: begin
            r_query_we   <= 1'b1;
            r_query_addr <= w_idx;
            r_query_word <= w_word;
            r_load_done  <= w_idx_wrap;
            if (w_idx_wrap) r_state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = (r_state != IDLE);
  assign state      = r_state;
  assign node_we    = r_node_we;
  assign node_addr  = r_node_addr;
  assign node_sel   = r_node_sel;
  assign leaf_we    = r_leaf_we;
  assign leaf_addr  = r_leaf_addr;
  assign leaf_patch = r_leaf_patch;
  assign leaf_word  = r_leaf_word;
  assign query_we   = r_query_we;
  assign query_addr = r_query_addr;
  assign query_word = r_query_word;
  assign wdata      = r_wdata;
  assign load_done  = r_load_done;

`ifdef LOAD_PERF_CNT_EN
  logic [31:0] r_kdtree_cycles, r_query_cycles;

  // The start-pulse cycle counts as the first tree-load cycle; both counters freeze in IDLE
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_kdtree_cycles <= '0;
      r_query_cycles  <= '0;
    end else if (load_kdtree) begin
      r_kdtree_cycles <= 32'd1;
      r_query_cycles  <= '0;
    end else begin
      if (r_state == NODES || r_state == LEAVES) r_kdtree_cycles <= r_kdtree_cycles + 32'd1;
      if (r_state == QUERIES) r_query_cycles <= r_query_cycles + 32'd1;
    end
  end

  assign kdtree_cycles = r_kdtree_cycles;
  assign query_cycles  = r_query_cycles;
`else
  assign kdtree_cycles = 32'd0;
  assign query_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_ann_load_sequencer.sv
// tb/tb_ann_load_sequencer.sv - scoreboard bench for ann_load_sequencer with a word-index reference model
module tb_ann_load_sequencer;

  localparam int NW = 126;
  localparam int LW = 3072;
  localparam int QW = 2470;

  logic        io_clk = 1'b0;
  logic        io_rst, load_kdtree, in_valid;
  logic [10:0] in_data;
  logic        in_ready, node_we, node_sel, leaf_we, query_we, load_done;
  logic [5:0]  node_addr, leaf_addr;
  logic [2:0]  leaf_patch, leaf_word, query_word;
  logic [8:0]  query_addr;
  logic [10:0] wdata;
  logic [1:0]  state;
  logic [31:0] kdtree_cycles, query_cycles;

  always #5 io_clk = ~io_clk;

  ann_load_sequencer dut (
    .io_clk(io_clk), .io_rst(io_rst), .load_kdtree(load_kdtree),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .node_we(node_we), .node_addr(node_addr), .node_sel(node_sel),
    .leaf_we(leaf_we), .leaf_addr(leaf_addr), .leaf_patch(leaf_patch), .leaf_word(leaf_word),
    .query_we(query_we), .query_addr(query_addr), .query_word(query_word),
    .wdata(wdata), .load_done(load_done), .state(state),
    .kdtree_cycles(kdtree_cycles), .query_cycles(query_cycles)
  );

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int data;
    int done;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int m_sec = 0;
  int m_k = 0;
  int exp_cnt[4] = '{0, 0, 0, 0};
  int mon_cnt[4] = '{0, 0, 0, 0};
  int exp_done = 0;
  int mon_done = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: section and position within section map directly to memory coordinates
  task automatic model_accept(input int d);
    exp_t e;
    e.kind = m_sec; e.a = 0; e.b = 0; e.c = 0; e.data = d; e.done = 0;
    if (m_sec == 1) begin
      e.a = m_k / 2; e.b = m_k % 2;
    end else if (m_sec == 2) begin
      e.a = m_k / 48; e.b = (m_k % 48) / 6; e.c = m_k % 6;
    end else if (m_sec == 3) begin
      e.a = m_k / 5; e.b = m_k % 5; e.done = (m_k == QW - 1) ? 1 : 0;
    end
    if (m_sec != 0) begin
      sbq.push_back(e);
      exp_cnt[m_sec]++;
      exp_done += e.done;
      m_k++;
      if (m_sec == 1 && m_k == NW) begin m_sec = 2; m_k = 0; end
      else if (m_sec == 2 && m_k == LW) begin m_sec = 3; m_k = 0; end
      else if (m_sec == 3 && m_k == QW) begin m_sec = 0; m_k = 0; end
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge io_clk) begin
    int n;
    int kind;
    exp_t e;
    n = int'(node_we) + int'(leaf_we) + int'(query_we);
    if (n > 1) chk("strobe_exclusive", n, 1);
    if (n == 1) begin
      kind = node_we ? 1 : (leaf_we ? 2 : 3);
      mon_cnt[kind]++;
      if (load_done) mon_done++;
      if (sbq.size() == 0) begin
        chk("unexpected_strobe_kind", kind, 0);
      end else begin
        e = sbq.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("wdata", int'(wdata), e.data);
        chk("load_done", int'(load_done), e.done);
        if (kind == 1) begin
          chk("node_addr", int'(node_addr), e.a);
          chk("node_sel", int'(node_sel), e.b);
        end else if (kind == 2) begin
          chk("leaf_addr", int'(leaf_addr), e.a);
          chk("leaf_patch", int'(leaf_patch), e.b);
          chk("leaf_word", int'(leaf_word), e.c);
        end else begin
          chk("query_addr", int'(query_addr), e.a);
          chk("query_word", int'(query_word), e.b);
        end
      end
    end else if (load_done) begin
      chk("load_done_without_strobe", 1, 0);
    end
  end

  task automatic beat(input int d);
    chk("in_ready", int'(in_ready), (m_sec != 0) ? 1 : 0);
    in_valid = 1'b1;
    in_data  = 11'(d);
    @(posedge io_clk);
    model_accept(d & 32'h7ff);
    @(negedge io_clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge io_clk);
  endtask

  task automatic pulse_load(input bit with_beat, input int d);
    load_kdtree = 1'b1;
    in_valid    = with_beat;
    in_data     = 11'(d);
    @(posedge io_clk);
    m_sec = 1; m_k = 0;
    @(negedge io_clk);
    load_kdtree = 1'b0;
    in_valid    = 1'b0;
    chk("state_after_load", int'(state), 1);
  endtask

  task automatic send(input int n, input bit rnd, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      beat(rnd ? int'($urandom_range(0, 2047)) : i);
    end
  endtask

  initial begin
    repeat (50000) @(posedge io_clk);
    $display("FAIL watchdog actual=%0d required=%0d", 50000, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    io_rst = 1'b1; load_kdtree = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge io_clk);
    @(negedge io_clk);
    io_rst = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_wdata", int'(wdata), 0);

    // A word offered while idle must not be written
    in_valid = 1'b1; in_data = 11'd7;
    @(negedge io_clk);
    in_valid = 1'b0;
    idle(2);
    chk("idle_state", int'(state), 0);

    // Pass 1: index-valued data, back-to-back except one gap before leaves
    pulse_load(1'b0, 0);
    send(NW, 1'b0, 0);
    chk("state_leaves", int'(state), 2);
    idle(1);
    send(LW, 1'b0, 0);
    chk("state_queries", int'(state), 3);
    send(QW, 1'b0, 0);
    chk("state_idle_after_load", int'(state), 0);
    chk("in_ready_after_load", int'(in_ready), 0);
`ifdef LOAD_PERF_CNT_EN
    chk("kdtree_cycles", int'(kdtree_cycles), 3200);
    chk("query_cycles", int'(query_cycles), 2470);
`else
    chk("kdtree_cycles", int'(kdtree_cycles), 0);
    chk("query_cycles", int'(query_cycles), 0);
`endif
    idle(2);

    // Reset mid-nodes with a beat presented during the reset cycle
    pulse_load(1'b0, 0);
    send(40, 1'b1, 10);
    idle(1);
    io_rst = 1'b1; in_valid = 1'b1; in_data = 11'h155;
    @(posedge io_clk);
    m_sec = 0; m_k = 0;
    @(negedge io_clk);
    io_rst = 1'b0; in_valid = 1'b0;
    chk("state_after_midload_reset", int'(state), 0);
    chk("in_ready_after_midload_reset", int'(in_ready), 0);
    idle(2);

    // Restart mid-leaves; the beat sharing the pulse cycle is dropped
    pulse_load(1'b0, 0);
    send(NW, 1'b1, 10);
    send(100, 1'b1, 10);
    pulse_load(1'b1, 11'h3ff);
    chk("in_ready_after_restart", int'(in_ready), 1);

    // Full random load with random gaps
    send(NW + LW + QW, 1'b1, 10);
    idle(3);
    chk("final_state", int'(state), 0);
    chk("queue_empty", sbq.size(), 0);
    chk("node_we_count", mon_cnt[1], exp_cnt[1]);
    chk("leaf_we_count", mon_cnt[2], exp_cnt[2]);
    chk("query_we_count", mon_cnt[3], exp_cnt[3]);
    chk("load_done_count", mon_done, exp_done);
    chk("load_done_total", mon_done, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
